// File: rtl/crc16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : crc16_pkg
//  Purpose  : Shared constants and types for the CRC-16 framer: generator
//             polynomial, default seed, FSM state encoding and the bit
//             positions of the fields inside the trailer word.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package crc16_pkg;

  // CRC-16, non-reflected, x^16 + x^12 + x^5 + 1
  localparam logic [15:0] CRC_POLY         = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEFAULT = 16'hFFFF;

  // Trailer word layout; bits above TRL_LEN_MSB are always zero
  localparam int TRL_CRC_LSB = 0;
  localparam int TRL_CRC_MSB = 15;
  localparam int TRL_LEN_LSB = 16;
  localparam int TRL_LEN_MSB = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,   // no packet open
    ST_PASS    = 2'd1,   // packet open, payload flowing
    ST_TRAILER = 2'd2    // last payload word taken, trailer not yet issued
  } state_t;

endpackage
`default_nettype wire

// File: rtl/crc16_upd64.sv
`default_nettype none
// ============================================================================
//  Module   : crc16_upd64
//  Purpose  : Combinational CRC-16 (poly 0x1021, non-reflected) advanced over
//             one 64-bit word, bit 63 first.
//  Ports    : crc_in  [15:0] - CRC before this word
//             data    [63:0] - word to absorb
//             crc_out [15:0] - CRC after this word
//  Revision : 1.0 - initial release
// ============================================================================
module crc16_upd64
  import crc16_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [63:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] w_acc;

  // Unrolled serial LFSR; synthesis flattens this into the XOR network.
  always_comb begin
    w_acc = crc_in;
    for (int i = 63; i >= 0; i--) begin
      if (w_acc[15] ^ data[i]) begin
        w_acc = {w_acc[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        w_acc = {w_acc[14:0], 1'b0};
      end
    end
    crc_out = w_acc;
  end

endmodule
`default_nettype wire

// File: rtl/crc16_framer.sv
`default_nettype none
// ============================================================================
//  Module   : crc16_framer
//  Purpose  : Passes a valid/ready stream of 64-bit payload words through a
//             single output register and appends one trailer word per packet
//             holding the CRC-16 of the payload. Defining macro
//             CRC16_FRAMER_LEN_EN adds a saturating word count to the trailer.
//  Ports    : clk, rst (sync, active-high)
//             in_valid / in_ready / in_data / in_last   - upstream
//             out_valid / out_ready / out_data / out_last - downstream
//             out_last marks the trailer word only.
//  Revision : 1.0 - initial release
// ============================================================================
module crc16_framer
  import crc16_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [15:0]       r_crc;
  logic [15:0]       w_crc_seed;
  logic [15:0]       w_crc_nxt;
  logic              w_slot_free;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_load_trl;
  logic [DATA_W-1:0] w_trailer;

  // The output register can take a new word when empty or draining now.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_in_ready  = (r_state != ST_TRAILER) && w_slot_free && !rst;
  assign w_accept    = in_valid && w_in_ready;

  // First word of a packet is absorbed from the seed, not the stale CRC.
  assign w_crc_seed = (r_state == ST_IDLE) ? CRC_INIT : r_crc;

  crc16_upd64 u_upd (
    .crc_in  (w_crc_seed),
    .data    (in_data),
    .crc_out (w_crc_nxt)
  );

`ifdef CRC16_FRAMER_LEN_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_cnt <= 16'd1;
      end else if (r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end else if (w_load_trl) begin
      r_cnt <= '0;
    end
  end
`endif

  always_comb begin
    w_trailer = '0;
    w_trailer[TRL_CRC_MSB:TRL_CRC_LSB] = r_crc;
`ifdef CRC16_FRAMER_LEN_EN
    w_trailer[TRL_LEN_MSB:TRL_LEN_LSB] = r_cnt;
`endif
  end

  // Next-state logic. The trailer leaves TRAILER as soon as it is loaded into
  // the output register, so the input is stalled for exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load_trl  = 1'b0;
    case (r_state)
      ST_IDLE, ST_PASS: begin
        if (w_accept) begin
          w_state_nxt = in_last ? ST_TRAILER : ST_PASS;
        end
      end
      ST_TRAILER: begin
        if (w_slot_free) begin
          w_load_trl  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_crc       <= CRC_INIT;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
      r_out_last  <= 1'b0;
      r_crc       <= w_crc_nxt;
    end else if (w_load_trl) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_trailer;
      r_out_last  <= 1'b1;
      r_crc       <= CRC_INIT;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_crc16_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc16_framer
//  Purpose  : Self-checking bench for crc16_framer. Expected output streams
//             come from a byte-wise CRC-16 model of each packet.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crc16_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;

  int n_pass  = 0;
  int n_total = 0;
  int stalls  = 0;
  int cyc     = 0;

  logic [64:0] got_q[$];
  int          got_t[$];
  logic [64:0] exp_q[$];

  crc16_framer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Output transfer monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_data});
      got_t.push_back(cyc);
    end
  end

  initial begin
    #(3000000);
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // CRC-16/0x1021 of the packet as a big-endian byte stream, seed FFFF
  function automatic logic [64:0] model_trailer(input logic [63:0] w[$]);
    logic [15:0] c;
    logic [63:0] t;
    c = 16'hFFFF;
    foreach (w[k]) begin
      t = w[k];
      for (int b = 7; b >= 0; b--) begin
        c = c ^ {t[b*8 +: 8], 8'h00};
        for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
`ifdef CRC16_FRAMER_LEN_EN
    return {1'b1, 32'h0, (w.size() > 65535) ? 16'hFFFF : 16'(w.size()), c};
`else
    return {1'b1, 32'h0, 16'h0, c};
`endif
  endfunction

  // One clock: drive at negedge, note acceptance, check hold after the edge.
  task automatic cycle(input logic v, input logic [63:0] d, input logic l,
                       input logic r, output logic acc);
    logic        stall;
    logic [64:0] snap;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    acc   = v && in_ready;
    stall = out_valid && !r;
    snap  = {out_last, out_data};
    @(posedge clk);
    #1;
    if (stall) begin
      chk("hold_valid", 65'(out_valid), 65'(1));
      chk("hold_word", {out_last, out_data}, snap);
    end
  endtask

  task automatic send_pkt(input logic [63:0] w[$], input bit rnd_rdy, input bit rnd_vld,
                          output int ncyc);
    int   idx;
    int   budget;
    logic acc;
    logic v;
    logic r;
    idx = 0; ncyc = 0;
    budget = w.size() * 8 + 64;
    foreach (w[k]) exp_q.push_back({1'b0, w[k]});
    exp_q.push_back(model_trailer(w));
    while (idx < w.size() && budget > 0) begin
      v = rnd_vld ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      r = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(v, w[idx], 1'(idx == w.size() - 1), r, acc);
      if (v && r && !acc) stalls++;
      if (acc) idx++;
      ncyc++;
      budget--;
    end
    if (idx < w.size()) chk("send_timeout", 65'(idx), 65'(w.size()));
  endtask

  task automatic drain(input string tag, output int span);
    int   b;
    logic acc;
    b = 0;
    while (got_q.size() < exp_q.size() && b < 400) begin
      cycle(1'b0, 64'h0, 1'b0, 1'b1, acc);
      b++;
    end
    repeat (3) cycle(1'b0, 64'h0, 1'b0, 1'b1, acc);
    chk({tag, "_count"}, 65'(got_q.size()), 65'(exp_q.size()));
    foreach (exp_q[k]) if (k < got_q.size()) chk(tag, got_q[k], exp_q[k]);
    span = (got_t.size() > 0) ? got_t[got_t.size()-1] - got_t[0] : -1;
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  initial begin
    logic [63:0] w[$];
    logic [63:0] w3[$];
    logic        acc;
    int          ncyc;
    int          span;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 65'(out_valid), 65'(0));
    chk("rst_out_data", 65'(out_data), 65'(0));
    chk("rst_out_last", 65'(out_last), 65'(0));
    chk("rst_in_ready", 65'(in_ready), 65'(0));
    @(negedge clk); rst = 1'b0;

    // Single-word packet: data at t+1, trailer at t+2
    w = '{64'h0123456789ABCDEF};
    send_pkt(w, 1'b0, 1'b0, ncyc);
    chk("t1_data", {out_valid, out_last, out_data}, {2'b10, 64'h0123456789ABCDEF});
    cycle(1'b0, 64'h0, 1'b0, 1'b1, acc);
    chk("t1_trailer", {out_valid, out_last, out_data}, {1'b1, model_trailer(w)});
    drain("t1", span);

    // Six-word packet with no gaps
    w = '{64'hFEDCBA9876543210};
    repeat (5) w.push_back({$urandom, $urandom});
    send_pkt(w, 1'b0, 1'b0, ncyc);
    chk("t2_in_cycles", 65'(ncyc), 65'(6));
    drain("t2", span);
    chk("t2_out_span", 65'(span), 65'(6));

    // Four-word packet with random backpressure, then again without
    w.delete();
    repeat (4) w.push_back({$urandom, $urandom});
    send_pkt(w, 1'b1, 1'b0, ncyc);
    drain("t3_rand", span);
    send_pkt(w, 1'b0, 1'b0, ncyc);
    drain("t3_full", span);

    // Back-to-back 2-word packets: one input stall for the first trailer
    w.delete();
    repeat (2) w.push_back({$urandom, $urandom});
    send_pkt(w, 1'b0, 1'b0, ncyc);
    stalls = 0;
    w.delete();
    repeat (2) w.push_back({$urandom, $urandom});
    send_pkt(w, 1'b0, 1'b0, ncyc);
    chk("t4_stalls", 65'(stalls), 65'(1));
    drain("t4", span);

    // Reset after two words of a three-word packet
    w3.delete();
    repeat (3) w3.push_back({$urandom, $urandom});
    cycle(1'b1, w3[0], 1'b0, 1'b1, acc);
    chk("t5_acc0", 65'(acc), 65'(1));
    cycle(1'b1, w3[1], 1'b0, 1'b1, acc);
    chk("t5_acc1", 65'(acc), 65'(1));
    exp_q.push_back({1'b0, w3[0]});
    exp_q.push_back({1'b0, w3[1]});
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("t5_rst_in_ready", 65'(in_ready), 65'(0));
    @(posedge clk); #1;
    chk("t5_rst_out_valid", 65'(out_valid), 65'(0));
    @(negedge clk); rst = 1'b0;
    drain("t5_discard", span);
    send_pkt(w3, 1'b0, 1'b0, ncyc);
    drain("t5_after", span);

    // Mixed random packets with random valid and ready
    for (int p = 0; p < 6; p++) begin
      w.delete();
      repeat ($urandom_range(1, 5)) w.push_back({$urandom, $urandom});
      send_pkt(w, 1'b1, 1'b1, ncyc);
    end
    drain("t6", span);

`ifdef CRC16_FRAMER_LEN_EN
    // Long packet: count field saturates
    w.delete();
    repeat (70000) w.push_back({$urandom, $urandom});
    send_pkt(w, 1'b0, 1'b0, ncyc);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, acc);
    chk("t7_count", 65'(out_data[31:16]), 65'(16'hFFFF));
    drain("t7", span);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
